vga_rom_arbiter: RTL
====================

Name: vga_rom_arbiter

Overview:
- Shares the single pixel/character ROM between two requesters.
  - Video fetch path: strict priority, one read per p_tick during active window.
  - Auxiliary requester: debug/readback or sprite loader, served in the gaps.
- Sits between the VGA pixel datapath and the rom instance.
- Owns rom_addr/rom_ce and returns tagged, registered read data to each requester.

Parameters:
- ADDR_W, 16, ROM address width.
- DATA_W, 8, ROM data width.
- STARVE_MAX, 1023, aux wait cycles before aux_starve asserts; counter width is clog2(STARVE_MAX+1).

Ports:
- clk_50MHz  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video read request; may assert on any cycle (normally on p_tick).
- vid_addr  in  ADDR_W  video read address, sampled when vid_req=1.
- vid_data  out  DATA_W  video read data.
- vid_valid  out  1  one-cycle pulse; vid_data valid.
- aux_req  in  1  aux read request; level, held with aux_addr stable until aux_gnt.
- aux_addr  in  ADDR_W  aux read address.
- aux_gnt  out  1  combinational; aux request accepted this cycle.
- aux_data  out  DATA_W  aux read data.
- aux_valid  out  1  one-cycle pulse; aux_data valid.
- aux_starve  out  1  sticky flag: aux waited more than STARVE_MAX cycles; cleared by next aux_gnt.
- rom_addr  out  ADDR_W  registered address to rom.
- rom_ce  out  1  registered chip enable; high only in cycles carrying an issued read.
- rom_data  in  DATA_W  rom output, combinational from rom_addr.

Behaviour:
- Reset (async assert, sync release): rom_addr=0, rom_ce=0, vid_data=0, vid_valid=0, aux_data=0, aux_valid=0, aux_starve=0, wait counter=0, pipeline tags=NONE.
- Arbitration, cycle N (combinational):
  - vid_req=1 → winner VID.
  - else aux_req=1 → winner AUX, aux_gnt=1.
  - else NONE.
  - aux_gnt = aux_req & ~vid_req. Video is never stalled or dropped.
- Stage 1, edge ending N:
  - rom_addr ← winner address; rom_ce ← (winner≠NONE); tag1 ← winner.
  - rom_addr holds its value when NONE.
- Stage 2, edge ending N+1:
  - tag1=VID → vid_data ← rom_data, vid_valid ← 1.
  - tag1=AUX → aux_data ← rom_data, aux_valid ← 1.
  - Valid flags for the non-selected side ← 0.
- Latency: request cycle N → valid high in cycle N+2.
- Throughput: one read per cycle, fully pipelined; back-to-back requests from either side are legal.
- Data registers hold the last value when not updated.
- Simultaneous vid_req and aux_req: VID issues; AUX waits with aux_gnt=0 and must keep aux_addr stable.
- Wait counter:
  - Increments each cycle aux_req=1 and aux_gnt=0; saturates at STARVE_MAX.
  - Clears to 0 when aux_gnt=1 or aux_req=0.
  - aux_starve sets on the cycle the counter reaches STARVE_MAX; clears on the next aux_gnt.
- aux_req dropped before grant: legal. Request withdrawn, no read issued, counter cleared.
- Reset mid-operation:
  - In-flight reads are discarded; no valid pulse follows reset release.
  - First request after release behaves as from idle.
- Address arithmetic: pass-through only, no wrap or offset. Window/address generation stays in the pixel datapath.

Decomposition:
- Shared package vga_pkg:
  - 2-bit tag encoding: TAG_NONE=0, TAG_VID=1, TAG_AUX=2.
  - Default ADDR_W/DATA_W constants, reused by rom and vga top.
- One natural sub-module: vga_rom_arb_starve, the saturating wait counter plus sticky flag.
- Pipeline and mux stay inline.

Test Plan:
- Reset: hold rst_n=0 with vid_req=1 and aux_req=1 → all outputs 0, aux_gnt=0 while vid_req=1. Release; idle → rom_ce stays 0.
- Video stream: vid_req every other cycle, addr 0,1,2…99, ROM model data=addr[7:0] → vid_valid pulses 2 cycles after each request, vid_data=0..99 in order, no gaps lost.
- Aux in gap: aux_req with aux_addr=16'h0040 while vid_req=0 → aux_gnt same cycle, aux_valid 2 cycles later, aux_data=8'h40.
- Collision: vid_req and aux_req both high in one cycle → video served first, aux_gnt the next free cycle. Both valids arrive in issue order, never in the same cycle.
- Starvation: STARVE_MAX=7, vid_req held high for 10 cycles with aux_req=1 → aux_starve rises after 7 waiting cycles; clears on the grant after vid_req drops.
- Mid-flight reset: assert rst_n=0 one cycle after a vid request → no vid_valid after release, vid_data=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: read-tag encoding and default ROM geometry.
package vga_pkg;

    localparam int VGA_ADDR_W = 16;
    localparam int VGA_DATA_W = 8;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_AUX  = 2'd2
    } tag_e;

endpackage

// File: rtl/vga_rom_arb_starve.sv
// Aux wait counter: saturating count of denied aux cycles plus a sticky
// starvation flag that only a grant can clear.
module vga_rom_arb_starve #(
    parameter int STARVE_MAX = 1023
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic aux_req_i,
    input  logic aux_gnt_i,
    output logic aux_starve_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starve_q, starve_d;
    logic          waiting;

    assign waiting = aux_req_i & ~aux_gnt_i;

    always_comb begin
        cnt_d    = '0;
        starve_d = starve_q;
        if (waiting)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Flag becomes visible in the same cycle the counter shows CNT_MAX.
        if (aux_gnt_i)
            starve_d = 1'b0;
        else if (waiting && cnt_d == CNT_MAX)
            starve_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign aux_starve_o = starve_q;

endmodule

// File: rtl/vga_rom_arbiter.sv
// Two-port ROM arbiter: video has strict priority, aux fills the gaps.
// Two-stage pipeline: issue (rom_addr/rom_ce/tag) then tagged data capture.
module vga_rom_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int DATA_W     = VGA_DATA_W,
    parameter int STARVE_MAX = 1023
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_data,
    output logic              aux_valid,
    output logic              aux_starve,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data
);

    tag_e              win;
    logic [ADDR_W-1:0] win_addr;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_ce_q, rom_ce_d;
    tag_e              tag1_q, tag1_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] aux_data_q, aux_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic              aux_valid_q, aux_valid_d;

    always_comb begin
        win      = TAG_NONE;
        win_addr = rom_addr_q;
        if (vid_req) begin
            win      = TAG_VID;
            win_addr = vid_addr;
        end else if (aux_req) begin
            win      = TAG_AUX;
            win_addr = aux_addr;
        end
    end

    assign aux_gnt = aux_req & ~vid_req;

    always_comb begin
        rom_addr_d  = win_addr;
        rom_ce_d    = (win != TAG_NONE);
        tag1_d      = win;
        vid_data_d  = vid_data_q;
        aux_data_d  = aux_data_q;
        vid_valid_d = 1'b0;
        aux_valid_d = 1'b0;
        // rom_data corresponds to the read issued on the previous edge.
        case (tag1_q)
            TAG_VID: begin
                vid_data_d  = rom_data;
                vid_valid_d = 1'b1;
            end
            TAG_AUX: begin
                aux_data_d  = rom_data;
                aux_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            rom_ce_q    <= 1'b0;
            tag1_q      <= TAG_NONE;
            vid_data_q  <= '0;
            aux_data_q  <= '0;
            vid_valid_q <= 1'b0;
            aux_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            rom_ce_q    <= rom_ce_d;
            tag1_q      <= tag1_d;
            vid_data_q  <= vid_data_d;
            aux_data_q  <= aux_data_d;
            vid_valid_q <= vid_valid_d;
            aux_valid_q <= aux_valid_d;
        end
    end

    vga_rom_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i        (clk_50MHz),
        .rst_ni       (rst_n),
        .aux_req_i    (aux_req),
        .aux_gnt_i    (aux_gnt),
        .aux_starve_o (aux_starve)
    );

    assign rom_addr  = rom_addr_q;
    assign rom_ce    = rom_ce_q;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign aux_data  = aux_data_q;
    assign aux_valid = aux_valid_q;

endmodule
